// File: rtl/bl_calc_pkg.sv
// Shared definitions for the baseline calculator.
//   - bl_state_t : controller state encoding
//   - default lane/counter widths and the derived accumulator width
//   - lane index constants (lane A occupies the lowest bits of a packed bus)
package bl_calc_pkg;

  localparam int ADC_W_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 11;
  localparam int ACC_WIDTH     = ADC_W_DEFAULT + CNT_W_DEFAULT;

  localparam int NUM_LANES = 4;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;
  localparam int LANE_D    = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } bl_state_t;

endpackage

// File: rtl/bl_div_seq.sv
// One-lane sequential restoring divider (unsigned).
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load dividend/divisor and begin; one quotient bit per cycle
//   dividend   : DIVIDEND_W-bit unsigned numerator
//   divisor    : DIVISOR_W-bit unsigned denominator
//   quotient   : low QUOT_W bits of the quotient; 0 when the divisor is 0
//   done       : high in the cycle the last quotient bit is being formed;
//                quotient is final from the following cycle onward
// Takes DIVIDEND_W cycles after start. A new start restarts at once.
module bl_div_seq
  import bl_calc_pkg::*;
#(
  parameter int DIVIDEND_W = ACC_WIDTH,
  parameter int DIVISOR_W  = CNT_W_DEFAULT,
  parameter int QUOT_W     = ADC_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int ITER_W = $clog2(DIVIDEND_W + 1);

  // q_reg starts as the dividend and is shifted left one bit per step; the
  // vacated LSBs fill with quotient bits, so after DIVIDEND_W steps it holds
  // the full quotient.
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  den;
  logic [ITER_W-1:0]     iter;
  logic                  run;

  logic [DIVISOR_W:0] rem_shift;
  logic [DIVISOR_W:0] rem_diff;
  logic               ge;

  // The remainder is always below the divisor, so it fits DIVISOR_W bits;
  // only the shifted trial value needs one extra bit.
  always_comb begin
    rem_shift = {rem, q_reg[DIVIDEND_W-1]};
    ge        = (rem_shift >= {1'b0, den});
    rem_diff  = rem_shift - {1'b0, den};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
      rem   <= '0;
      den   <= '0;
      iter  <= '0;
      run   <= 1'b0;
    end else if (start) begin
      q_reg <= dividend;
      rem   <= '0;
      den   <= divisor;
      iter  <= ITER_W'(DIVIDEND_W);
      run   <= 1'b1;
    end else if (run) begin
      rem   <= ge ? rem_diff[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
      q_reg <= {q_reg[DIVIDEND_W-2:0], ge};
      iter  <= iter - 1'b1;
      if (iter == ITER_W'(1)) run <= 1'b0;
    end
  end

  assign done     = run && (iter == ITER_W'(1));
  // A zero divisor would otherwise produce all ones.
  assign quotient = (den == '0) ? '0 : q_reg[QUOT_W-1:0];

endmodule

// File: rtl/bl_calc.sv
// Baseline calculator: per-lane signed mean of a baseline sample window.
//   clk, rst_n    : clock, synchronous active-low reset
//   din           : four packed two's-complement lanes, A in the low bits
//   data_BL_valid : din carries a baseline sample this cycle
//   BL            : per-lane mean (truncated toward zero), same packing as din
//   BL_update     : one-cycle strobe; BL is new in this cycle and holds
//   bl_busy       : high from the first accepted sample until after BL_update
//   bl_count      : number of samples behind the current BL
// A window is a run of consecutive valid cycles. Its first invalid cycle
// (t0) starts the division; BL/BL_update appear at t0+29. A valid sample
// during DIV/FIX/DONE abandons the pending result and opens a new window.
module bl_calc
  import bl_calc_pkg::*;
#(
  parameter int ADC_BIT_WIDTH = ADC_W_DEFAULT,
  parameter int CNT_WIDTH     = CNT_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4*ADC_BIT_WIDTH-1:0]   din,
  input  logic                         data_BL_valid,
  output logic [4*ADC_BIT_WIDTH-1:0]   BL,
  output logic                         BL_update,
  output logic                         bl_busy,
  output logic [CNT_WIDTH-1:0]         bl_count
);

  localparam int ACC_W = ADC_BIT_WIDTH + CNT_WIDTH;

  bl_state_t              state;
  logic [ACC_W-1:0]       acc      [NUM_LANES];
  logic [CNT_WIDTH-1:0]   count;
  logic [NUM_LANES-1:0]   sign_q;

  logic [ACC_W-1:0]          lane_ext [NUM_LANES];
  logic [ACC_W-1:0]          acc_abs  [NUM_LANES];
  logic [ADC_BIT_WIDTH-1:0]  quot     [NUM_LANES];
  logic [NUM_LANES-1:0]      div_done;
  logic [4*ADC_BIT_WIDTH-1:0] bl_next;
  logic                      div_start;
  logic                      count_full;

  always_comb begin
    bl_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_ext[i] = {{CNT_WIDTH{din[i*ADC_BIT_WIDTH+ADC_BIT_WIDTH-1]}},
                     din[i*ADC_BIT_WIDTH +: ADC_BIT_WIDTH]};
      acc_abs[i]  = acc[i][ACC_W-1] ? (~acc[i] + 1'b1) : acc[i];
      // Mean of in-range samples is in range, so the low bits are exact.
      bl_next[i*ADC_BIT_WIDTH +: ADC_BIT_WIDTH] =
        sign_q[i] ? (~quot[i] + 1'b1) : quot[i];
    end
  end

  assign count_full = (count == {CNT_WIDTH{1'b1}});
  // The dividers capture |acc| and count on the edge that leaves ACC.
  assign div_start  = (state == ST_ACC) && !data_BL_valid;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bl_div_seq #(
      .DIVIDEND_W (ACC_W),
      .DIVISOR_W  (CNT_WIDTH),
      .QUOT_W     (ADC_BIT_WIDTH)
    ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (acc_abs[g]),
      .divisor  (count),
      .quotient (quot[g]),
      .done     (div_done[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      sign_q    <= '0;
      BL        <= '0;
      BL_update <= 1'b0;
      bl_busy   <= 1'b0;
      bl_count  <= '0;
      for (int i = 0; i < NUM_LANES; i++) acc[i] <= '0;
    end else begin
      BL_update <= 1'b0;
      if (data_BL_valid && (state != ST_ACC)) begin
        // First sample of a new window; also abandons any pending result.
        for (int i = 0; i < NUM_LANES; i++) acc[i] <= lane_ext[i];
        count   <= CNT_WIDTH'(1);
        bl_busy <= 1'b1;
        state   <= ST_ACC;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ACC: begin
            if (data_BL_valid) begin
              if (!count_full) begin
                for (int i = 0; i < NUM_LANES; i++) acc[i] <= acc[i] + lane_ext[i];
                count <= count + 1'b1;
              end
            end else begin
              for (int i = 0; i < NUM_LANES; i++) sign_q[i] <= acc[i][ACC_W-1];
              state <= ST_DIV;
            end
          end
          ST_DIV: begin
            if (&div_done) state <= ST_FIX;
          end
          ST_FIX: begin
            BL        <= bl_next;
            bl_count  <= count;
            BL_update <= 1'b1;
            state     <= ST_DONE;
          end
          ST_DONE: begin
            bl_busy <= 1'b0;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bl_calc.sv
module tb_bl_calc;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic        data_BL_valid;
  logic [63:0] BL;
  logic        BL_update;
  logic        bl_busy;
  logic [10:0] bl_count;

  always #5 clk = ~clk;

  bl_calc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .data_BL_valid (data_BL_valid),
    .BL            (BL),
    .BL_update     (BL_update),
    .bl_busy       (bl_busy),
    .bl_count      (bl_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Windows are summed with wide integers; the mean is plain signed division
  // (which truncates toward zero). A finished window's result appears 29
  // cycles after its first idle cycle unless a sample arrives before then.
  longint      m_sum [4];
  int          m_cnt;
  bit          m_open;
  bit          m_pend;
  int          m_t0;
  logic [63:0] m_pend_bl;
  int          m_pend_cnt;
  logic [63:0] exp_bl;
  logic        exp_upd;
  logic        exp_busy;
  logic [10:0] exp_cnt;
  bit          model_ok = 0;

  always @(posedge clk) begin
    longint q;
    exp_upd = 1'b0;
    if (!rst_n) begin
      m_open = 0; m_pend = 0; m_cnt = 0;
      exp_bl = '0; exp_cnt = '0; exp_busy = 1'b0;
    end else begin
      if (m_pend) begin
        if (data_BL_valid && cyc <= m_t0 + 28) m_pend = 0;
        else if (cyc == m_t0 + 28) begin
          exp_upd = 1'b1;
          exp_bl  = m_pend_bl;
          exp_cnt = 11'(m_pend_cnt);
        end
      end
      if (data_BL_valid) begin
        if (!m_open) begin
          m_open = 1; m_cnt = 0;
          for (int i = 0; i < 4; i++) m_sum[i] = 0;
        end
        if (m_cnt < 2047) begin
          m_cnt++;
          for (int i = 0; i < 4; i++) m_sum[i] += longint'($signed(din[i*16 +: 16]));
        end
      end else if (m_open) begin
        m_open = 0; m_pend = 1; m_t0 = cyc; m_pend_cnt = m_cnt;
        for (int i = 0; i < 4; i++) begin
          q = m_sum[i] / longint'(m_cnt);
          m_pend_bl[i*16 +: 16] = q[15:0];
        end
      end
      if (m_pend && cyc + 1 > m_t0 + 29) m_pend = 0;
      exp_busy = m_open || m_pend;
    end
    model_ok = 1;
    cyc++;
  end

  // ---------------- compare process ----------------
  int strobes = 0;
  int last_strobe = -1;

  always @(negedge clk) begin
    if (model_ok) begin
      check("bl", BL, exp_bl);
      check("bl_update", 64'(BL_update), 64'(exp_upd));
      check("bl_busy", 64'(bl_busy), 64'(exp_busy));
      check("bl_count", 64'(bl_count), 64'(exp_cnt));
      if (BL_update === 1'b1) begin
        strobes++;
        last_strobe = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] v);
    data_BL_valid = 1'b1;
    din = v;
    @(posedge clk); #1;
  endtask

  task automatic end_window(output int t0);
    data_BL_valid = 1'b0;
    din = {$urandom, $urandom};
    t0 = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    data_BL_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'(($urandom_range(0, 20)) - 10);
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, s0;
    rst_n = 1'b0; data_BL_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bl", BL, 64'h0);
    check("reset_busy", 64'(bl_busy), 64'h0);
    check("reset_count", 64'(bl_count), 64'h0);
    check("reset_update", 64'(BL_update), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // constant window
    s0 = strobes;
    repeat (8) send({4{16'd100}});
    end_window(t0);
    idle(35);
    check("const_strobes", 64'(strobes - s0), 64'd1);
    check("const_time", 64'(last_strobe), 64'(t0 + 29));
    check("const_bl", BL, {4{16'd100}});
    check("const_count", 64'(bl_count), 64'd8);
    check("const_model", exp_bl, {4{16'd100}});

    // signed truncation toward zero
    send({16'd0, 16'd0, 16'd5, 16'hFFFD});
    send({16'd0, 16'd0, 16'd6, 16'hFFFC});
    end_window(t0);
    idle(35);
    check("trunc_bl", BL, {16'd0, 16'd0, 16'd5, 16'hFFFD});
    check("trunc_count", 64'(bl_count), 64'd2);
    check("trunc_model", exp_bl, {16'd0, 16'd0, 16'd5, 16'hFFFD});

    // extremes
    repeat (1023) send({16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000});
    end_window(t0);
    idle(35);
    check("ext_bl", BL, {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000});
    check("ext_count", 64'(bl_count), 64'd1023);
    check("ext_time", 64'(last_strobe), 64'(t0 + 29));

    // abort during division
    s0 = strobes;
    repeat (8) send({4{16'd10}});
    end_window(t0);
    while (cyc < t0 + 10) idle(1);
    repeat (5) send({4{16'd20}});
    end_window(t1);
    idle(35);
    check("abort_strobes", 64'(strobes - s0), 64'd1);
    check("abort_time", 64'(last_strobe), 64'(t1 + 29));
    check("abort_bl", BL, {4{16'd20}});
    check("abort_count", 64'(bl_count), 64'd5);

    // counter saturation
    repeat (2100) send({4{16'd7}});
    end_window(t0);
    idle(35);
    check("sat_count", 64'(bl_count), 64'd2047);
    check("sat_bl", BL, {4{16'd7}});
    check("sat_model", 64'(exp_cnt), 64'd2047);

    // reset in the middle of division
    s0 = strobes;
    repeat (4) send({4{16'd50}});
    end_window(t0);
    while (cyc < t0 + 15) idle(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_bl", BL, 64'h0);
    check("rst_busy", 64'(bl_busy), 64'h0);
    idle(40);
    check("rst_strobes", 64'(strobes - s0), 64'd0);
    check("rst_bl_after", BL, 64'h0);

    // randomized windows with random gaps (short gaps exercise abort)
    for (int w = 0; w < 40; w++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        send({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
      end_window(t0);
      idle($urandom_range(0, 39));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
